// File: rtl/key_filter_pkg.sv
// rtl/key_filter_pkg.sv - shared state encoding and sizing helpers for the key filter
//
// Contents:
//   kf_state_e        per-channel FSM state (3-bit encoding)
//   kf_clog2()        ceiling log2 for parameter-time sizing
//   kf_cnt_width()    width of the shared per-channel counter

package key_filter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    LONG_HELD  = 3'd3,
    RELEASE_DB = 3'd4
  } kf_state_e;

  function automatic int kf_clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        width = i + 1;
      end
    end
    return width;
  endfunction

  // One counter serves every state, so it is sized for the largest period.
  function automatic int kf_cnt_width(input int debounce_cyc, input int long_cyc,
                                      input int repeat_cyc);
    int max_cyc;
    int width;
    max_cyc = debounce_cyc;
    if (long_cyc > max_cyc) begin
      max_cyc = long_cyc;
    end
    if (repeat_cyc > max_cyc) begin
      max_cyc = repeat_cyc;
    end
    width = kf_clog2(max_cyc + 1);
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/key_filter_channel.sv
// rtl/key_filter_channel.sv - one key: synchroniser, polarity normaliser, debounce/hold FSM
//
// Ports:
//   clk_i          system tick clock
//   reset_ni       asynchronous active-low reset
//   btn_i          raw asynchronous key input
//   stable_flag_o  debounced pressed level
//   press_o        one-cycle pulse on accepted press
//   release_o      one-cycle pulse on accepted release
//   long_press_o   one-cycle pulse when the hold reaches LONG_CYC
//   repeat_o       one-cycle pulse every REPEAT_CYC while long-held

module key_filter_channel
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 1000,
  parameter int REPEAT_CYC   = 200,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic stable_flag_o,
  output logic press_o,
  output logic release_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int CNT_W = kf_cnt_width(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);

  // Raw level of a released key; the synchroniser resets to it so that
  // leaving reset never looks like a fresh press.
  localparam logic INACTIVE_LVL = ACTIVE_HIGH ? 1'b0 : 1'b1;

  // The sample that leaves IDLE (or a held state) is already the first of
  // the DEBOUNCE_CYC required, so the last one arrives with cnt_q at
  // DEBOUNCE_CYC-2. DEBOUNCE_CYC==1 never enters a debounce state.
  localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'((DEBOUNCE_CYC >= 2) ? DEBOUNCE_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'((LONG_CYC >= 1) ? LONG_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'((REPEAT_CYC >= 1) ? REPEAT_CYC - 1 : 0);

  logic             sync1_q;
  logic             sync2_q;
  logic             pressed;

  kf_state_e        state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             long_q,    long_d;
  logic             stable_q,  stable_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;
  logic             lpress_q,  lpress_d;
  logic             repeat_q,  repeat_d;

  assign pressed = ACTIVE_HIGH ? sync2_q : ~sync2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q   <= INACTIVE_LVL;
      sync2_q   <= INACTIVE_LVL;
      state_q   <= IDLE;
      cnt_q     <= '0;
      long_q    <= 1'b0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      lpress_q  <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      long_q    <= long_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      lpress_q  <= lpress_d;
      repeat_q  <= repeat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    long_d    = long_q;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    lpress_d  = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pressed) begin
          cnt_d = '0;
          if (DEBOUNCE_CYC == 1) begin
            state_d  = HELD;
            stable_d = 1'b1;
            press_d  = 1'b1;
            long_d   = 1'b0;
          end else begin
            state_d = PRESS_DB;
          end
        end
      end

      PRESS_DB: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_TERM) begin
          state_d  = HELD;
          stable_d = 1'b1;
          press_d  = 1'b1;
          long_d   = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HELD, LONG_HELD: begin
        if (!pressed) begin
          cnt_d = '0;
          if (DEBOUNCE_CYC == 1) begin
            state_d   = IDLE;
            stable_d  = 1'b0;
            release_d = 1'b1;
            long_d    = 1'b0;
          end else begin
            state_d = RELEASE_DB;
          end
        end else if (state_q == HELD) begin
          if (LONG_CYC != 0) begin
            if (cnt_q == LONG_TERM) begin
              state_d  = LONG_HELD;
              lpress_d = 1'b1;
              long_d   = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else begin
          if (REPEAT_CYC != 0) begin
            if (cnt_q == REP_TERM) begin
              repeat_d = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      RELEASE_DB: begin
        if (pressed) begin
          // Release bounce: resume holding, the hold period starts over.
          state_d = long_q ? LONG_HELD : HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_TERM) begin
          state_d   = IDLE;
          stable_d  = 1'b0;
          release_d = 1'b1;
          long_d    = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable_flag_o = stable_q;
  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = lpress_q;
  assign repeat_o      = repeat_q;

endmodule

// File: rtl/key_filter_array.sv
// rtl/key_filter_array.sv - N_KEYS independent debounced key channels
//
// Ports (one bit per key in every vector):
//   clk_i          system tick clock
//   reset_ni       asynchronous active-low reset
//   btn_i          raw asynchronous key inputs
//   stable_flag_o  debounced pressed levels
//   press_o        accepted-press pulses
//   release_o      accepted-release pulses
//   long_press_o   long-press pulses
//   repeat_o       auto-repeat pulses

module key_filter_array
  import key_filter_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int LONG_CYC     = 1000,
  parameter int REPEAT_CYC   = 200,
  parameter bit ACTIVE_HIGH  = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [N_KEYS-1:0] btn_i,
  output logic [N_KEYS-1:0] stable_flag_o,
  output logic [N_KEYS-1:0] press_o,
  output logic [N_KEYS-1:0] release_o,
  output logic [N_KEYS-1:0] long_press_o,
  output logic [N_KEYS-1:0] repeat_o
);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_filter_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC),
      .ACTIVE_HIGH  (ACTIVE_HIGH)
    ) u_channel (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .btn_i         (btn_i[k]),
      .stable_flag_o (stable_flag_o[k]),
      .press_o       (press_o[k]),
      .release_o     (release_o[k]),
      .long_press_o  (long_press_o[k]),
      .repeat_o      (repeat_o[k])
    );
  end

endmodule

// File: tb/tb_key_filter_array.sv
// tb/tb_key_filter_array.sv - bench for key_filter_array, both polarities against one key model

module tb_key_filter_array;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 16;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn;
  logic [N-1:0] btn_n;

  logic [N-1:0] hi_stable, hi_press, hi_rel, hi_long, hi_rep;
  logic [N-1:0] lo_stable, lo_press, lo_rel, lo_long, lo_rep;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  key_filter_array #(
    .N_KEYS(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .ACTIVE_HIGH(1'b1)
  ) dut_hi (
    .clk_i(clk), .reset_ni(rst_n), .btn_i(btn),
    .stable_flag_o(hi_stable), .press_o(hi_press), .release_o(hi_rel),
    .long_press_o(hi_long), .repeat_o(hi_rep)
  );

  key_filter_array #(
    .N_KEYS(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .ACTIVE_HIGH(1'b0)
  ) dut_lo (
    .clk_i(clk), .reset_ni(rst_n), .btn_i(btn_n),
    .stable_flag_o(lo_stable), .press_o(lo_press), .release_o(lo_rel),
    .long_press_o(lo_long), .repeat_o(lo_rep)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: run lengths of samples disagreeing with the debounced
  // level, plus a hold timer measured from press / last pulse / bounce recovery.
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] e_stable, e_press, e_rel, e_long, e_rep;
  int           m_run[N];
  int           m_tmr[N];
  bit           m_lf[N];
  int           dwell[N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0;
    e_stable = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_tmr[k] = 0; m_lf[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    s = m_s2; m_s2 = m_s1; m_s1 = btn;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int k = 0; k < N; k++) begin
      if (!e_stable[k]) begin
        m_run[k] = s[k] ? m_run[k] + 1 : 0;
        if (m_run[k] == D) begin
          e_stable[k] = 1'b1; e_press[k] = 1'b1;
          m_run[k] = 0; m_tmr[k] = 0; m_lf[k] = 1'b0;
        end
      end else if (!s[k]) begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] == D) begin
          e_stable[k] = 1'b0; e_rel[k] = 1'b1;
          m_run[k] = 0; m_lf[k] = 1'b0;
        end
      end else if (m_run[k] != 0) begin
        m_run[k] = 0; m_tmr[k] = 0;
      end else begin
        m_tmr[k] = m_tmr[k] + 1;
        if (!m_lf[k] && m_tmr[k] == L) begin
          e_long[k] = 1'b1; m_lf[k] = 1'b1; m_tmr[k] = 0;
        end else if (m_lf[k] && m_tmr[k] == R) begin
          e_rep[k] = 1'b1; m_tmr[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hi.stable", hi_stable, e_stable);
    chk("hi.press",  hi_press,  e_press);
    chk("hi.release", hi_rel,   e_rel);
    chk("hi.long",   hi_long,   e_long);
    chk("hi.repeat", hi_rep,    e_rep);
    chk("lo.stable", lo_stable, e_stable);
    chk("lo.press",  lo_press,  e_press);
    chk("lo.release", lo_rel,   e_rel);
    chk("lo.long",   lo_long,   e_long);
    chk("lo.repeat", lo_rep,    e_rep);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    cyc++;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = '0;
    model_reset();

    // Reset and quiet period afterwards
    for (int i = 0; i < 3; i++) step();
    chk("rst.stable", hi_stable, 4'b0000);
    chk("rst.lo_stable", lo_stable, 4'b0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("quiet.press", hi_press | lo_press, 4'b0000);
    end

    // Clean press and release on key 0
    btn[0] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      chk("s2.press", hi_press, (t == 6) ? 4'b0001 : 4'b0000);
      chk("s2.stable", hi_stable, (t >= 6) ? 4'b0001 : 4'b0000);
    end
    btn[0] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      chk("s2.release", hi_rel, (t == 6) ? 4'b0001 : 4'b0000);
      chk("s2.stable_r", hi_stable, (t < 6) ? 4'b0001 : 4'b0000);
      chk("s2.long", hi_long, 4'b0000);
    end

    // Press bounce on key 1, then release glitches of 1..3 cycles
    for (int b = 0; b < 4; b++) begin
      btn[1] = ~btn[1];
      step(); step();
      chk("s3.bounce", hi_press, 4'b0000);
    end
    btn[1] = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      step();
      chk("s3.press", hi_press, (t == 6) ? 4'b0010 : 4'b0000);
    end
    for (int g = 1; g <= 3; g++) begin
      btn[1] = 1'b0;
      for (int i = 0; i < g; i++) step();
      btn[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step();
        chk("s3.glitch", hi_rel, 4'b0000);
        chk("s3.glitch_st", hi_stable, 4'b0010);
      end
    end
    btn[1] = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Long hold on key 2 with auto-repeat
    btn[2] = 1'b1;
    for (int t = 1; t <= 48; t++) begin
      step();
      chk("s4.press", hi_press, (t == 6) ? 4'b0100 : 4'b0000);
      chk("s4.long", hi_long, (t == 22) ? 4'b0100 : 4'b0000);
      chk("s4.repeat", hi_rep,
          (t == 26 || t == 30 || t == 34 || t == 38 || t == 42) ? 4'b0100 : 4'b0000);
      chk("s4.release", hi_rel, (t == 46) ? 4'b0100 : 4'b0000);
      if (t == 40) btn[2] = 1'b0;
    end

    // Simultaneous keys, then release only key 0
    btn = 4'b1111;
    for (int t = 1; t <= 6; t++) begin
      step();
      chk("s5.press", hi_press, (t == 6) ? 4'b1111 : 4'b0000);
    end
    btn[0] = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      step();
      chk("s5.release", hi_rel, (t == 6) ? 4'b0001 : 4'b0000);
    end

    // Reset while keys 1..3 are long-held
    for (int i = 0; i < 12; i++) step();
    chk("s6.longheld", hi_stable, 4'b1110);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("s6.async_st", hi_stable, 4'b0000);
    chk("s6.async_lo", lo_stable, 4'b0000);
    check_all();
    step(); step();
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      step();
      chk("s6.repress", hi_press, (t == 6) ? 4'b1110 : 4'b0000);
      chk("s6.norel", hi_rel, 4'b0000);
    end

    // Randomised mix of bounces, short taps and long holds
    btn = '0;
    for (int i = 0; i < 8; i++) step();
    for (int k = 0; k < N; k++) dwell[k] = int'($urandom_range(1, 10));
    for (int i = 0; i < 700; i++) begin
      for (int k = 0; k < N; k++) begin
        if (dwell[k] == 0) begin
          btn[k] = ~btn[k];
          dwell[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 5))
                                                 : int'($urandom_range(6, 60));
        end else begin
          dwell[k] = dwell[k] - 1;
        end
      end
      if (i == 350) begin
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
      end
      if (i == 353) rst_n = 1'b1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_filter_array.md
Name: key_filter_array

Overview:
- Parametrised multi-channel successor to the single-key debouncer.
- Filters N_KEYS independent asynchronous button inputs. Per key it produces:
  - a debounced level;
  - one-cycle press and release pulses;
  - a long-press pulse;
  - optional auto-repeat pulses.
- Sits between the board push-buttons and the water-level controller's mode/setpoint logic. Runs on the 1 kHz system tick clock.

Parameters:
- N_KEYS, 4: number of independent key channels (>=1).
- DEBOUNCE_CYC, 20: consecutive stable samples required to accept a press or release (>=1). Default is 20 ms at 1 kHz.
- LONG_CYC, 1000: further held cycles after an accepted press before long_press fires. 0 disables long-press and repeat.
- REPEAT_CYC, 200: repeat pulse period while long-held. 0 disables repeat.
- ACTIVE_HIGH, 1: 1 = pressed key reads 1; 0 = pressed key reads 0.

Ports:
- clk  input  1  system clock (1 kHz tick domain).
- reset  input  1  asynchronous, active-low reset; clears all state.
- btn  input  N_KEYS  raw asynchronous key inputs.
- stable_flag  output  N_KEYS  debounced pressed level per key.
- press  output  N_KEYS  one-cycle pulse on accepted press.
- release  output  N_KEYS  one-cycle pulse on accepted release.
- long_press  output  N_KEYS  one-cycle pulse when hold reaches LONG_CYC.
- repeat  output  N_KEYS  one-cycle pulse every REPEAT_CYC while long-held.

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, every channel state IDLE, counters 0, long flag 0;
  - synchroniser flops load the inactive raw level (0 if ACTIVE_HIGH=1, 1 if ACTIVE_HIGH=0), so no spurious press occurs after reset release;
  - reset asserted mid-hold: outputs drop to 0 asynchronously and no release pulse is generated.
- Input path:
  - each btn bit passes a 2-flop synchroniser;
  - it is then normalised to s = pressed(1)/released(0) per ACTIVE_HIGH.
- Per-channel FSM, all outputs registered. States and transitions:
  - IDLE: if s=1, go to PRESS_DB, cnt=0.
  - PRESS_DB:
    - s=0: go to IDLE (bounce rejected, no output);
    - else cnt++;
    - when cnt reaches DEBOUNCE_CYC-1 with s=1: go to HELD, stable_flag<=1, press pulse, cnt=0.
  - HELD:
    - s=0: go to RELEASE_DB, cnt=0;
    - else if LONG_CYC!=0, cnt++; at cnt=LONG_CYC-1: long_press pulse, set long flag, go to LONG_HELD, cnt=0.
  - LONG_HELD:
    - s=0: go to RELEASE_DB, cnt=0;
    - else if REPEAT_CYC!=0, cnt++; at cnt=REPEAT_CYC-1: repeat pulse, cnt=0. This is periodic.
  - RELEASE_DB:
    - s=1 (bounce): return to LONG_HELD if long flag is set, else HELD; cnt restarts at 0; stable_flag stays 1; no pulses;
    - s=0 for DEBOUNCE_CYC consecutive cycles: go to IDLE, stable_flag<=0, release pulse, long flag cleared.
- Latency:
  - btn change held stable to press (or release) pulse = 2 + DEBOUNCE_CYC clk cycles;
  - press to first long_press = LONG_CYC cycles;
  - long_press to first repeat = REPEAT_CYC cycles.
- Pulse timing within a channel:
  - press, release, long_press and repeat are mutually exclusive in any cycle;
  - each is high exactly one cycle.
- Channel independence: channels are fully independent; simultaneous events on several keys produce simultaneous pulses.
- Counter: a single per-channel counter is shared across states. Width = clog2(max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)+1). It never wraps because every state resets it at its terminal value.

Decomposition:
- Shared header key_filter_pkg, as `include / localparam file. It holds:
  - FSM state encodings: IDLE, PRESS_DB, HELD, LONG_HELD, RELEASE_DB (3-bit);
  - the clog2 width function.
- Sub-module key_filter_channel: synchroniser, normaliser, FSM and counter for one key. Takes the same parameters minus N_KEYS.
- key_filter_array is a generate loop of N_KEYS instances of key_filter_channel.

Test Plan:
Use DEBOUNCE_CYC=4, LONG_CYC=16, REPEAT_CYC=4, N_KEYS=4 for all scenarios.
1. Reset sequence -> all outputs 0 while reset=0; no pulse for 10 cycles after release with btn=0. Repeat with ACTIVE_HIGH=0 and btn=all 1s -> still no pulse.
2. Clean press, btn[0]=1 for 10 cycles then 0 -> press[0] one cycle exactly 6 cycles after rise; stable_flag[0]=1 until release[0] pulses 6 cycles after the fall; no long_press.
3. Bounce rejection, btn[1] toggling 1,0,1,0 at 2-cycle intervals, then stable 1 -> no pulse during toggling; a single press 6 cycles after the final rise. Release glitches of 1-3 cycles produce no release.
4. Long hold, btn[2]=1 for 40 cycles -> press at t=6, long_press at t=22, repeat at t=26, 30, 34, 38, 42, then release after btn falls.
5. Simultaneous keys, btn[3:0]=4'b1111 on the same edge -> four press pulses in the same cycle; drop btn[0] only -> only release[0].
6. Reset mid-hold, assert reset during LONG_HELD -> outputs 0 immediately; no release pulse. After reset release with btn still held -> fresh press 6 cycles later.
